rob_param: RTL and testbench

- Parametrised reorder buffer; successor to the fixed 16-entry ROB.
- Sits between decoder (allocation, operand lookup), ALU/LSB (writeback), regfile/LSB (in-order commit) and ifetch (redirect/branch update).
- New versus the previous generation: generic depth and widths; full-width occupancy count; JALR target prediction (flush only on a wrong target); explicit flush pulse; one-slot full margin.

---
 rtl/rob_param.sv | 231 +++++++++++++++++++++++
 tb/tb_rob_param.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback, in-order commit, branch/JALR redirect.
// Optional build macro ROB_WB_BYPASS_EN lets operand queries see same-cycle ALU/LSB writebacks.
module rob_param #(
   parameter int DEPTH  = 16,
   parameter int ID_W   = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int OP_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              full,
   output logic [ID_W-1:0]   tail_id,
   output logic [ID_W-1:0]   head_id,
   input  logic              iss_valid,
   input  logic [OP_W-1:0]   iss_op,
   input  logic [REG_W-1:0]  iss_rd,
   input  logic [ADDR_W-1:0] iss_pc,
   input  logic              iss_ready,
   input  logic              iss_pred_taken,
   input  logic [ADDR_W-1:0] iss_pred_target,
   input  logic              alu_wb,
   input  logic [ID_W-1:0]   alu_id,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_taken,
   input  logic [ADDR_W-1:0] alu_target,
   input  logic              lsb_wb,
   input  logic [ID_W-1:0]   lsb_id,
   input  logic [DATA_W-1:0] lsb_data,
   input  logic              q1_en,
   input  logic [ID_W-1:0]   q1_id,
   output logic              q1_hit,
   output logic [DATA_W-1:0] q1_data,
   input  logic              q2_en,
   input  logic [ID_W-1:0]   q2_id,
   output logic              q2_hit,
   output logic [DATA_W-1:0] q2_data,
   output logic              cm_reg_valid,
   output logic [REG_W-1:0]  cm_reg_rd,
   output logic [DATA_W-1:0] cm_reg_data,
   output logic [ID_W-1:0]   cm_id,
   output logic [ADDR_W-1:0] cm_pc,
   output logic              cm_st_valid,
   output logic              br_upd,
   output logic              br_taken,
   output logic              flush,
   output logic              redir_valid,
   output logic [ADDR_W-1:0] redir_pc
);

   localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
   localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);
   localparam logic [OP_W-1:0] OP_JALR   = OP_W'(7'b1100111);
   localparam logic [ID_W:0]   FULL_LVL  = (ID_W+1)'(DEPTH-1);
   localparam logic [ID_W-1:0] ID_ONE    = ID_W'(1);

   // Pointers and occupancy
   logic [ID_W-1:0] head, tail;
   logic [ID_W:0]   count;

   // Per-entry control bits (reset) and payload (not reset)
   logic [DEPTH-1:0]  e_busy, e_ready;
   logic [DEPTH-1:0]  e_taken, e_pred_taken;
   logic [OP_W-1:0]   e_op          [DEPTH];
   logic [REG_W-1:0]  e_rd          [DEPTH];
   logic [ADDR_W-1:0] e_pc          [DEPTH];
   logic [DATA_W-1:0] e_data        [DEPTH];
   logic [ADDR_W-1:0] e_target      [DEPTH];
   logic [ADDR_W-1:0] e_pred_target [DEPTH];

   logic            live;
   logic            do_issue, do_commit, alu_acc, lsb_acc;
   logic            cm_is_store, cm_is_branch, cm_is_jalr, cm_mispredict;
   logic [ID_W:0]   cnt_inc, cnt_dec;

   assign head_id = head;
   assign tail_id = tail;
   // full comes from the registered count only, so issue never loops back into it
   assign full    = (count >= FULL_LVL);

   // While flush is high the cycle is dead: nothing is accepted, state clears at its edge
   assign live      = rdy & ~flush & ~rst;
   assign do_issue  = live & iss_valid & ~full;
   assign do_commit = live & (count != '0) & e_ready[head];
   assign alu_acc   = live & alu_wb & e_busy[alu_id];
   assign lsb_acc   = live & lsb_wb & e_busy[lsb_id] & ~(alu_wb & (alu_id == lsb_id));

   assign cnt_inc = {{ID_W{1'b0}}, do_issue};
   assign cnt_dec = {{ID_W{1'b0}}, do_commit};

   always_comb begin
      cm_is_store   = (e_op[head] == OP_STORE);
      cm_is_branch  = (e_op[head] == OP_BRANCH);
      cm_is_jalr    = (e_op[head] == OP_JALR);
      cm_mispredict = 1'b0;
      if (cm_is_branch)
         cm_mispredict = (e_taken[head] != e_pred_taken[head]);
      else if (cm_is_jalr)
         cm_mispredict = (e_target[head] != e_pred_target[head]);
   end

   always_comb begin
      q1_hit  = 1'b0;
      q1_data = '0;
      if (q1_en && e_busy[q1_id]) begin
`ifdef ROB_WB_BYPASS_EN
         if (live && alu_wb && (alu_id == q1_id)) begin
            q1_hit  = 1'b1;
            q1_data = alu_data;
         end else if (live && lsb_wb && (lsb_id == q1_id)) begin
            q1_hit  = 1'b1;
            q1_data = lsb_data;
         end else
`endif
         if (e_ready[q1_id]) begin
            q1_hit  = 1'b1;
            q1_data = e_data[q1_id];
         end
      end
   end

   always_comb begin
      q2_hit  = 1'b0;
      q2_data = '0;
      if (q2_en && e_busy[q2_id]) begin
`ifdef ROB_WB_BYPASS_EN
         if (live && alu_wb && (alu_id == q2_id)) begin
            q2_hit  = 1'b1;
            q2_data = alu_data;
         end else if (live && lsb_wb && (lsb_id == q2_id)) begin
            q2_hit  = 1'b1;
            q2_data = lsb_data;
         end else
`endif
         if (e_ready[q2_id]) begin
            q2_hit  = 1'b1;
            q2_data = e_data[q2_id];
         end
      end
   end

   // Control state, pointers and commit outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         e_busy       <= '0;
         e_ready      <= '0;
         cm_reg_valid <= 1'b0;
         cm_st_valid  <= 1'b0;
         br_upd       <= 1'b0;
         flush        <= 1'b0;
         redir_valid  <= 1'b0;
         br_taken     <= 1'b0;
         cm_reg_rd    <= '0;
         cm_reg_data  <= '0;
         cm_id        <= '0;
         cm_pc        <= '0;
         redir_pc     <= '0;
      end else if (rdy) begin
         cm_reg_valid <= 1'b0;
         cm_st_valid  <= 1'b0;
         br_upd       <= 1'b0;
         flush        <= 1'b0;
         redir_valid  <= 1'b0;
         if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_busy  <= '0;
            e_ready <= '0;
         end else begin
            if (alu_acc) e_ready[alu_id] <= 1'b1;
            if (lsb_acc) e_ready[lsb_id] <= 1'b1;
            if (do_commit) begin
               e_busy[head] <= 1'b0;
               head         <= head + ID_ONE;
               cm_id        <= head;
               cm_pc        <= e_pc[head];
               if (cm_is_store) begin
                  cm_st_valid <= 1'b1;
               end else if (cm_is_branch) begin
                  br_upd   <= 1'b1;
                  br_taken <= e_taken[head];
               end else begin
                  cm_reg_valid <= 1'b1;
                  cm_reg_rd    <= e_rd[head];
                  cm_reg_data  <= e_data[head];
               end
               if (cm_mispredict) begin
                  flush       <= 1'b1;
                  redir_valid <= 1'b1;
                  redir_pc    <= e_target[head];
               end
            end
            // Issue is written last so it overrides anything aimed at the new tail entry
            if (do_issue) begin
               e_busy[tail]  <= 1'b1;
               e_ready[tail] <= iss_ready;
               tail          <= tail + ID_ONE;
            end
            count <= count + cnt_inc - cnt_dec;
         end
      end
   end

   // NOTE: entry payload has no reset; busy/ready qualify every read of it, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (alu_acc) begin
         e_data[alu_id]   <= alu_data;
         e_taken[alu_id]  <= alu_taken;
         e_target[alu_id] <= alu_target;
      end
      if (lsb_acc)
         e_data[lsb_id] <= lsb_data;
      if (do_issue) begin
         e_op[tail]          <= iss_op;
         e_rd[tail]          <= iss_rd;
         e_pc[tail]          <= iss_pc;
         e_pred_taken[tail]  <= iss_pred_taken;
         e_pred_target[tail] <= iss_pred_target;
         e_data[tail]        <= '0;
         e_taken[tail]       <= 1'b0;
         e_target[tail]      <= '0;
      end
   end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: queue-based reference model checked every cycle plus directed literal checks.
// Build with +define+ROB_WB_BYPASS_EN to check the same-cycle query bypass variant.
module tb_rob_param;

   localparam int DEPTH = 16;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef ROB_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk, rst, rdy;
   logic        full;
   logic [3:0]  tail_id, head_id;
   logic        iss_valid, iss_ready, iss_pred_taken;
   logic [6:0]  iss_op;
   logic [4:0]  iss_rd;
   logic [31:0] iss_pc, iss_pred_target;
   logic        alu_wb, alu_taken;
   logic [3:0]  alu_id;
   logic [31:0] alu_data, alu_target;
   logic        lsb_wb;
   logic [3:0]  lsb_id;
   logic [31:0] lsb_data;
   logic        q1_en, q2_en, q1_hit, q2_hit;
   logic [3:0]  q1_id, q2_id;
   logic [31:0] q1_data, q2_data;
   logic        cm_reg_valid, cm_st_valid, br_upd, br_taken, flush, redir_valid;
   logic [4:0]  cm_reg_rd;
   logic [31:0] cm_reg_data, cm_pc, redir_pc;
   logic [3:0]  cm_id;

   rob_param #(.DEPTH(16), .ID_W(4), .DATA_W(32), .ADDR_W(32), .REG_W(5), .OP_W(7)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .full(full), .tail_id(tail_id), .head_id(head_id),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_rd(iss_rd), .iss_pc(iss_pc),
      .iss_ready(iss_ready), .iss_pred_taken(iss_pred_taken), .iss_pred_target(iss_pred_target),
      .alu_wb(alu_wb), .alu_id(alu_id), .alu_data(alu_data), .alu_taken(alu_taken),
      .alu_target(alu_target), .lsb_wb(lsb_wb), .lsb_id(lsb_id), .lsb_data(lsb_data),
      .q1_en(q1_en), .q1_id(q1_id), .q1_hit(q1_hit), .q1_data(q1_data),
      .q2_en(q2_en), .q2_id(q2_id), .q2_hit(q2_hit), .q2_data(q2_data),
      .cm_reg_valid(cm_reg_valid), .cm_reg_rd(cm_reg_rd), .cm_reg_data(cm_reg_data),
      .cm_id(cm_id), .cm_pc(cm_pc), .cm_st_valid(cm_st_valid), .br_upd(br_upd),
      .br_taken(br_taken), .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: program-order queue of in-flight instructions
   typedef struct {
      int          id;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] pc;
      bit          ready;
      logic [31:0] data;
      bit          taken;
      logic [31:0] target;
      bit          pred_taken;
      logic [31:0] pred_target;
   } ent_t;

   ent_t rob[$];
   ent_t m_h, m_new;
   int   m_head, m_sz, m_tl;
   bit   m_cm;
   bit   x_cm_reg_valid, x_cm_st_valid, x_br_upd, x_br_taken, x_flush, x_redir_valid;
   logic [4:0]  x_cm_reg_rd;
   logic [31:0] x_cm_reg_data, x_cm_pc, x_redir_pc;
   int   x_cm_id;

   always @(posedge clk) begin
      if (rst) begin
         rob.delete();
         m_head = 0;
         x_cm_reg_valid = 0; x_cm_st_valid = 0; x_br_upd = 0; x_br_taken = 0;
         x_flush = 0; x_redir_valid = 0; x_cm_reg_rd = '0; x_cm_reg_data = '0;
         x_cm_pc = '0; x_redir_pc = '0; x_cm_id = 0;
      end else if (rdy) begin
         if (x_flush) begin
            rob.delete();
            m_head = 0;
            x_cm_reg_valid = 0; x_cm_st_valid = 0; x_br_upd = 0; x_flush = 0; x_redir_valid = 0;
         end else begin
            m_sz = rob.size();
            m_tl = (m_head + m_sz) % DEPTH;
            m_cm = (m_sz > 0) && rob[0].ready;
            if (m_cm) m_h = rob[0];
            foreach (rob[i]) begin
               if (alu_wb && rob[i].id == int'(alu_id)) begin
                  rob[i].ready = 1; rob[i].data = alu_data;
                  rob[i].taken = alu_taken; rob[i].target = alu_target;
               end else if (lsb_wb && rob[i].id == int'(lsb_id)) begin
                  rob[i].ready = 1; rob[i].data = lsb_data;
               end
            end
            x_cm_reg_valid = 0; x_cm_st_valid = 0; x_br_upd = 0; x_flush = 0; x_redir_valid = 0;
            if (m_cm) begin
               rob.delete(0);
               m_head = (m_head + 1) % DEPTH;
               x_cm_id = m_h.id;
               x_cm_pc = m_h.pc;
               if (m_h.op == OP_STORE) x_cm_st_valid = 1;
               else if (m_h.op == OP_BRANCH) begin
                  x_br_upd = 1; x_br_taken = m_h.taken;
               end else begin
                  x_cm_reg_valid = 1; x_cm_reg_rd = m_h.rd; x_cm_reg_data = m_h.data;
               end
               if ((m_h.op == OP_BRANCH && m_h.taken != m_h.pred_taken) ||
                   (m_h.op == OP_JALR && m_h.target != m_h.pred_target)) begin
                  x_flush = 1; x_redir_valid = 1; x_redir_pc = m_h.target;
               end
            end
            if (iss_valid && m_sz < DEPTH - 1) begin
               m_new.id = m_tl; m_new.op = iss_op; m_new.rd = iss_rd; m_new.pc = iss_pc;
               m_new.ready = iss_ready; m_new.data = '0; m_new.taken = 0; m_new.target = '0;
               m_new.pred_taken = iss_pred_taken; m_new.pred_target = iss_pred_target;
               rob.push_back(m_new);
            end
         end
      end
   end

   function automatic logic [32:0] q_model(input logic en, input logic [3:0] id);
      if (!en) return '0;
      foreach (rob[i]) begin
         if (rob[i].id == int'(id)) begin
            if (BYPASS && rdy && !rst && !x_flush && alu_wb && alu_id == id) return {1'b1, alu_data};
            if (BYPASS && rdy && !rst && !x_flush && lsb_wb && lsb_id == id) return {1'b1, lsb_data};
            if (rob[i].ready) return {1'b1, rob[i].data};
            return '0;
         end
      end
      return '0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_full",      full,         rob.size() >= DEPTH - 1);
         check("m_tail_id",   tail_id,      (m_head + rob.size()) % DEPTH);
         check("m_head_id",   head_id,      m_head);
         check("m_cm_reg_v",  cm_reg_valid, x_cm_reg_valid);
         check("m_cm_reg_rd", cm_reg_rd,    x_cm_reg_rd);
         check("m_cm_data",   cm_reg_data,  x_cm_reg_data);
         check("m_cm_id",     cm_id,        x_cm_id);
         check("m_cm_pc",     cm_pc,        x_cm_pc);
         check("m_cm_st_v",   cm_st_valid,  x_cm_st_valid);
         check("m_br_upd",    br_upd,       x_br_upd);
         check("m_br_taken",  br_taken,     x_br_taken);
         check("m_flush",     flush,        x_flush);
         check("m_redir_v",   redir_valid,  x_redir_valid);
         check("m_redir_pc",  redir_pc,     x_redir_pc);
         check("m_q1",        {q1_hit, q1_data}, q_model(q1_en, q1_id));
         check("m_q2",        {q2_hit, q2_data}, q_model(q2_en, q2_id));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      iss_valid = 0; iss_op = '0; iss_rd = '0; iss_pc = '0; iss_ready = 0;
      iss_pred_taken = 0; iss_pred_target = '0;
      alu_wb = 0; alu_id = '0; alu_data = '0; alu_taken = 0; alu_target = '0;
      lsb_wb = 0; lsb_id = '0; lsb_data = '0;
      q1_en = 0; q1_id = '0; q2_en = 0; q2_id = '0;
   endtask

   task automatic set_iss(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                          input logic rd_y, input logic pt, input logic [31:0] ptgt);
      iss_valid = 1; iss_op = op; iss_rd = rd; iss_pc = pc; iss_ready = rd_y;
      iss_pred_taken = pt; iss_pred_target = ptgt;
   endtask

   task automatic wb_alu(input logic [3:0] id, input logic [31:0] d, input logic tk, input logic [31:0] tg);
      alu_wb = 1; alu_id = id; alu_data = d; alu_taken = tk; alu_target = tg;
   endtask

   task automatic wb_lsb(input logic [3:0] id, input logic [31:0] d);
      lsb_wb = 1; lsb_id = id; lsb_data = d;
   endtask

   task automatic do_reset();
      clr_in();
      rdy = 1;
      rst = 1;
      cyc();
      cyc();
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected done");
      $fatal(1, "watchdog");
   end

   logic [3:0] diff;

   initial begin
      clr_in();
      rdy = 1;
      rst = 1;
      cyc();
      chk_en = 1;
      do_reset();
      check("rst_full", full, 0);
      check("rst_tail", tail_id, 0);
      check("rst_head", head_id, 0);
      check("rst_flush", {cm_reg_valid, cm_st_valid, br_upd, flush, redir_valid}, 0);

      // Fill to the full margin, then an ignored issue
      for (int i = 0; i < 15; i++) begin
         set_iss(OP_ALU, 5'(i), 32'h1000 + 32'(4 * i), 0, 0, 0);
         cyc();
      end
      clr_in();
      check("fill_full", full, 1);
      check("fill_tail", tail_id, 15);
      set_iss(OP_ALU, 5'd20, 32'h2000, 0, 0, 0);
      cyc();
      clr_in();
      check("full_tail_held", tail_id, 15);
      check("full_head", head_id, 0);

      // Simple ALU commit
      do_reset();
      set_iss(OP_ALU, 5'd5, 32'h200, 0, 0, 0);
      cyc();
      clr_in(); wb_alu(0, 32'h1234, 0, 0);
      cyc();
      clr_in();
      cyc();
      check("alu_cm_valid", cm_reg_valid, 1);
      check("alu_cm_rd", cm_reg_rd, 5);
      check("alu_cm_data", cm_reg_data, 32'h1234);
      check("alu_cm_id", cm_id, 0);
      check("alu_head", head_id, 1);
      // rdy low: everything holds, including the pulse
      rdy = 0;
      set_iss(OP_ALU, 5'd6, 32'h204, 0, 0, 0);
      cyc();
      check("rdy_hold_pulse", cm_reg_valid, 1);
      check("rdy_hold_tail", tail_id, 1);
      rdy = 1; clr_in();
      cyc();
      check("pulse_drop", cm_reg_valid, 0);
      // Store ready at issue
      set_iss(OP_STORE, 5'd0, 32'h300, 1, 0, 0);
      cyc();
      clr_in();
      cyc();
      check("st_valid", cm_st_valid, 1);
      check("st_no_reg", cm_reg_valid, 0);
      check("st_id", cm_id, 1);
      check("st_data_held", cm_reg_data, 32'h1234);
      // ALU and LSB write the same entry: ALU wins
      set_iss(OP_ALU, 5'd9, 32'h304, 0, 0, 0);
      cyc();
      clr_in(); wb_alu(2, 32'h11, 0, 0); wb_lsb(2, 32'h22);
      cyc();
      clr_in();
      cyc();
      check("alu_wins", cm_reg_data, 32'h11);
      // Load completed by the LSB
      set_iss(OP_LOAD, 5'd10, 32'h308, 0, 0, 0);
      cyc();
      clr_in(); wb_lsb(3, 32'h77);
      cyc();
      clr_in();
      cyc();
      check("load_data", cm_reg_data, 32'h77);
      check("load_rd", cm_reg_rd, 10);

      // Mispredicted branch, with a younger issue discarded
      do_reset();
      set_iss(OP_BRANCH, 5'd0, 32'h100, 0, 0, 0);
      cyc();
      clr_in(); wb_alu(0, 0, 1, 32'h140);
      cyc();
      clr_in(); set_iss(OP_ALU, 5'd7, 32'h104, 0, 0, 0);
      cyc();
      check("br_upd", br_upd, 1);
      check("br_taken", br_taken, 1);
      check("br_flush", flush, 1);
      check("br_redir_v", redir_valid, 1);
      check("br_redir_pc", redir_pc, 32'h140);
      check("br_no_reg", cm_reg_valid, 0);
      set_iss(OP_ALU, 5'd8, 32'h140, 0, 0, 0);
      cyc();
      clr_in();
      check("post_flush", flush, 0);
      check("post_flush_head", head_id, 0);
      check("post_flush_tail", tail_id, 0);
      check("post_flush_full", full, 0);
      // Correctly predicted taken branch
      set_iss(OP_BRANCH, 5'd0, 32'h110, 0, 1, 0);
      cyc();
      clr_in(); wb_alu(0, 0, 1, 32'h160);
      cyc();
      clr_in();
      cyc();
      check("br_ok_upd", br_upd, 1);
      check("br_ok_noflush", flush, 0);
      check("br_ok_pc_held", redir_pc, 32'h140);

      // JALR: correct target, then wrong target
      set_iss(OP_JALR, 5'd1, 32'h180, 0, 0, 32'h200);
      cyc();
      clr_in(); wb_alu(1, 32'h184, 1, 32'h200);
      cyc();
      clr_in();
      cyc();
      check("jalr_ok_reg", cm_reg_valid, 1);
      check("jalr_ok_data", cm_reg_data, 32'h184);
      check("jalr_ok_noflush", flush, 0);
      set_iss(OP_JALR, 5'd2, 32'h190, 0, 0, 32'h200);
      cyc();
      clr_in(); wb_alu(2, 32'h194, 1, 32'h204);
      cyc();
      clr_in();
      cyc();
      check("jalr_bad_reg", cm_reg_valid, 1);
      check("jalr_bad_flush", flush, 1);
      check("jalr_bad_pc", redir_pc, 32'h204);
      check("jalr_bad_id", cm_id, 2);
      cyc();
      check("jalr_flush_head", head_id, 0);

      // Streaming 40 ops: each written back the cycle after issue, committed the cycle after that
      do_reset();
      for (int k = 0; k < 40; k++) begin
         clr_in();
         set_iss(OP_ALU, 5'(k % 32), 32'h400 + 32'(4 * k), 0, 0, 0);
         if (k > 0) wb_alu(4'((k - 1) % 16), 32'h1000 + 32'(k - 1), 0, 0);
         cyc();
         if (k >= 1) begin
            diff = tail_id - head_id;
            check("stream_count", diff, 2);
         end
         if (k >= 2) check("stream_cm_id", cm_id, (k - 2) % 16);
      end
      clr_in(); wb_alu(4'd7, 32'h1027, 0, 0);
      cyc();
      clr_in();
      cyc();
      check("stream_last_id", cm_id, 7);
      check("stream_last_data", cm_reg_data, 32'h1027);
      check("stream_head", head_id, 8);
      check("stream_tail", tail_id, 8);

      // Operand queries
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_iss(OP_ALU, 5'(i + 1), 32'h500 + 32'(4 * i), 0, 0, 0);
         cyc();
      end
      clr_in();
      q1_en = 1; q1_id = 3; wb_alu(3, 32'hAB, 0, 0);
      q2_en = 1; q2_id = 0;
      #1;
      check("q1_same_hit", q1_hit, BYPASS);
      check("q1_same_data", q1_data, BYPASS ? 32'hAB : 32'h0);
      check("q2_notready", {q2_hit, q2_data}, 0);
      cyc();
      alu_wb = 0;
      #1;
      check("q1_next_hit", q1_hit, 1);
      check("q1_next_data", q1_data, 32'hAB);
      q1_en = 0;
      #1;
      check("q1_disabled", {q1_hit, q1_data}, 0);
      q2_en = 1; q2_id = 1; wb_alu(1, 32'h11, 0, 0); wb_lsb(1, 32'h22);
      #1;
      check("q2_bypass_alu", q2_data, BYPASS ? 32'h11 : 32'h0);
      cyc();
      clr_in(); q2_en = 1; q2_id = 1;
      #1;
      check("q2_reg_alu", {q2_hit, q2_data}, {1'b1, 32'h11});
      cyc();
      clr_in();
      cyc();

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
